// File: rtl/gps_channel_wb_regs.sv
// Wishbone B4 classic register bank for one GPS correlator channel (control words, accumulator snapshots, status).
// Latency: ack and read data one cycle after the request; writes are visible on the outputs one cycle after the request.
// Backpressure: none; every matched request is acked after one cycle, and ack then drops for at least one cycle.
module gps_channel_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h00000A00,
    parameter int          ACC_W     = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic             dump_i,
    input  logic [ACC_W-1:0] acc_ip_i,
    input  logic [ACC_W-1:0] acc_qp_i,
    input  logic [ACC_W-1:0] acc_il_i,
    input  logic [ACC_W-1:0] acc_ql_i,
    input  logic [ACC_W-1:0] acc_ie_i,
    input  logic [ACC_W-1:0] acc_qe_i,
    output logic [31:0]      code_freq_o,
    output logic [31:0]      carr_freq_o,
    output logic [31:0]      code_off_o,
    output logic [31:0]      carr_off_o,
    output logic [31:0]      acq_thresh_o,
    output logic [31:0]      config_o,
    output logic             cfg_update_o
);

    localparam int NREG = 6;

    // Word index into the register map; the two byte-lane address bits carry no meaning here.
    localparam logic [5:0] W_STATUS = 6'd12;

    logic [NREG-1:0][31:0] ctrl_q, ctrl_d;
    logic [NREG-1:0][31:0] snap_q, snap_d;
    logic                  ready_q, ready_d;
    logic                  ovr_q, ovr_d;
    logic                  ack_q;
    logic [31:0]           dat_q;
    logic                  cfg_upd_q;

    logic        addr_hit;
    logic        req;
    logic        wr;
    logic        rd;
    logic [5:0]  word;
    logic [31:0] bmask;
    logic        ctrl_wr;
    logic        stat_wr;
    logic        ready_eff;
    logic        ovr_eff;
    logic [31:0] rd_dat;
    logic        unused_adr_lsb;

    assign addr_hit       = (wb_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req            = wb_cyc_i & wb_stb_i & ~ack_q & addr_hit;
    assign wr             = req & wb_we_i;
    assign rd             = req & ~wb_we_i;
    assign word           = wb_adr_i[7:2];
    assign unused_adr_lsb = ^wb_adr_i[1:0];
    assign bmask          = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign ctrl_wr        = wr & (word < 6'(NREG));
    assign stat_wr        = wr & (word == W_STATUS) & wb_sel_i[0];

    // Status clear is applied before the dump decision, so a clear and a dump in the
    // same cycle behave as "clear, then fresh dump into an empty snapshot set".
    assign ready_eff = ready_q & ~(stat_wr & ~wb_dat_i[0]);
    assign ovr_eff   = ovr_q & ~(stat_wr & ~wb_dat_i[1]);

    // Control-register writes with per-byte enables.
    always_comb begin
        ctrl_d = ctrl_q;
        for (int i = 0; i < NREG; i++) begin
            if (ctrl_wr && (word == 6'(i))) begin
                ctrl_d[i] = (ctrl_q[i] & ~bmask) | (wb_dat_i & bmask);
            end
        end
    end

    // Snapshot capture and ready/overrun status tracking.
    always_comb begin
        snap_d  = snap_q;
        ready_d = ready_eff | dump_i;
        ovr_d   = ovr_eff | (dump_i & ready_eff);
        if (dump_i && !ready_eff) begin
            snap_d[0] = 32'($signed(acc_ip_i));
            snap_d[1] = 32'($signed(acc_qp_i));
            snap_d[2] = 32'($signed(acc_il_i));
            snap_d[3] = 32'($signed(acc_ql_i));
            snap_d[4] = 32'($signed(acc_ie_i));
            snap_d[5] = 32'($signed(acc_qe_i));
        end
    end

    // Read mux over the register map; unmapped offsets read as zero.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NREG; i++) begin
            if (word == 6'(i)) begin
                rd_dat = ctrl_q[i];
            end
            if (word == 6'(i + NREG)) begin
                rd_dat = snap_q[i];
            end
        end
        if (word == W_STATUS) begin
            rd_dat = {30'd0, ovr_q, ready_q};
        end
    end

    // State registers; read data is captured from pre-update values alongside the ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q    <= '0;
            snap_q    <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            cfg_upd_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            snap_q    <= snap_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            ack_q     <= req;
            dat_q     <= rd ? rd_dat : 32'd0;
            cfg_upd_q <= ctrl_wr;
        end
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign cfg_update_o = cfg_upd_q;
    assign code_freq_o  = ctrl_q[0];
    assign carr_freq_o  = ctrl_q[1];
    assign code_off_o   = ctrl_q[2];
    assign carr_off_o   = ctrl_q[3];
    assign acq_thresh_o = ctrl_q[4];
    assign config_o     = ctrl_q[5];

endmodule
